// File: rtl/dit_frame_loader_if.sv
// Sample stream and frame presentation bundle between a sample source, the
// frame loader and the 8-point FFT core that consumes whole frames.
interface dit_frame_loader_if #(
    parameter int DW = 3,
    parameter int CW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 abort;
    logic                 frame_valid;
    logic                 frame_ready;
    logic signed [DW-1:0] xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7;
    logic signed [DW-1:0] xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7;
    logic [CW-1:0]        frame_cnt;
    logic [3:0]           fill_level;

    modport master (
        output in_valid, in_re, in_im, abort, frame_ready,
        input  in_ready, frame_valid, frame_cnt, fill_level,
        input  xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7,
        input  xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7
    );

    modport slave (
        input  in_valid, in_re, in_im, abort, frame_ready,
        output in_ready, frame_valid, frame_cnt, fill_level,
        output xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7,
        output xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7
    );
endinterface

// File: rtl/dit_frame_loader.sv
// Double-buffered frame assembler: collects 8 complex samples in natural order
// into a load buffer and hands complete frames to a hold buffer for the FFT.
module dit_frame_loader #(
    parameter int DW = 3,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    dit_frame_loader_if.slave bus
);
    logic signed [DW-1:0] load_re_r [8];
    logic signed [DW-1:0] load_im_r [8];
    logic signed [DW-1:0] hold_re_r [8];
    logic signed [DW-1:0] hold_im_r [8];
    logic [2:0]           wr_cnt_r;
    logic                 load_full_r;
    logic                 frame_valid_r;
    logic [CW-1:0]        frame_cnt_r;

    logic xfer_cond_s;
    logic xfer_s;
    logic in_ready_s;
    logic accept_s;

    // Handshake decode; in_ready ignores abort so it never depends on it combinationally
    always_comb begin
        xfer_cond_s = load_full_r && (!frame_valid_r || bus.frame_ready);
        xfer_s      = xfer_cond_s && !bus.abort;
        if (rst) begin
            in_ready_s = !load_full_r || xfer_cond_s;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = bus.in_valid && in_ready_s && !bus.abort;
    end

    // Load buffer: sample write pointer, full flag and slot storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_r    <= 3'd0;
            load_full_r <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                load_re_r[k] <= {DW{1'b0}};
                load_im_r[k] <= {DW{1'b0}};
            end
        end else if (bus.abort) begin
            wr_cnt_r    <= 3'd0;
            load_full_r <= 1'b0;
        end else begin
            if (accept_s) begin
                load_re_r[wr_cnt_r] <= bus.in_re;
                load_im_r[wr_cnt_r] <= bus.in_im;
                wr_cnt_r            <= wr_cnt_r + 3'd1;
            end
            // A full load buffer always has wr_cnt at 0, so set and clear never collide
            if (accept_s && (wr_cnt_r == 3'd7)) begin
                load_full_r <= 1'b1;
            end else if (xfer_s) begin
                load_full_r <= 1'b0;
            end
        end
    end

    // Hold buffer: takes the pre-edge load contents on transfer, releases on consume
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_valid_r <= 1'b0;
            frame_cnt_r   <= {CW{1'b0}};
            for (int k = 0; k < 8; k++) begin
                hold_re_r[k] <= {DW{1'b0}};
                hold_im_r[k] <= {DW{1'b0}};
            end
        end else if (xfer_s) begin
            frame_valid_r <= 1'b1;
            frame_cnt_r   <= frame_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            hold_re_r     <= load_re_r;
            hold_im_r     <= load_im_r;
        end else if (frame_valid_r && bus.frame_ready) begin
            frame_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_cnt   = frame_cnt_r;
    assign bus.fill_level  = load_full_r ? 4'd8 : {1'b0, wr_cnt_r};

    assign bus.xr0 = hold_re_r[0];
    assign bus.xr1 = hold_re_r[1];
    assign bus.xr2 = hold_re_r[2];
    assign bus.xr3 = hold_re_r[3];
    assign bus.xr4 = hold_re_r[4];
    assign bus.xr5 = hold_re_r[5];
    assign bus.xr6 = hold_re_r[6];
    assign bus.xr7 = hold_re_r[7];
    assign bus.xi0 = hold_im_r[0];
    assign bus.xi1 = hold_im_r[1];
    assign bus.xi2 = hold_im_r[2];
    assign bus.xi3 = hold_im_r[3];
    assign bus.xi4 = hold_im_r[4];
    assign bus.xi5 = hold_im_r[5];
    assign bus.xi6 = hold_im_r[6];
    assign bus.xi7 = hold_im_r[7];
endmodule

// File: tb/tb_dit_frame_loader.sv
// Directed bench for dit_frame_loader: hand-computed frames, back-pressure,
// abort, continuous streaming, asynchronous reset and extreme values.
module tb_dit_frame_loader;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   ready_drops;

    dit_frame_loader_if #(.DW(3), .CW(8)) bus ();

    dit_frame_loader #(.DW(3), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [2:0] xr_a [8];
    logic signed [2:0] xi_a [8];
    assign xr_a[0] = bus.xr0;
    assign xr_a[1] = bus.xr1;
    assign xr_a[2] = bus.xr2;
    assign xr_a[3] = bus.xr3;
    assign xr_a[4] = bus.xr4;
    assign xr_a[5] = bus.xr5;
    assign xr_a[6] = bus.xr6;
    assign xr_a[7] = bus.xr7;
    assign xi_a[0] = bus.xi0;
    assign xi_a[1] = bus.xi1;
    assign xi_a[2] = bus.xi2;
    assign xi_a[3] = bus.xi3;
    assign xi_a[4] = bus.xi4;
    assign xi_a[5] = bus.xi5;
    assign xi_a[6] = bus.xi6;
    assign xi_a[7] = bus.xi7;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample for one clock edge, noting whether the loader was ready
    task automatic push(input int re, input int im);
        bus.in_valid = 1'b1;
        bus.in_re    = re[2:0];
        bus.in_im    = im[2:0];
        #1;
        if (bus.in_ready !== 1'b1) ready_drops++;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        ready_drops = 0;
        rst             = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_re       = 3'd0;
        bus.in_im       = 3'd0;
        bus.abort       = 1'b0;
        bus.frame_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_frame_valid", bus.frame_valid, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        chk("rst_xr0", xr_a[0], 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_fill", bus.fill_level, 0);

        // 1: one frame, frame_ready high
        @(negedge clk);
        bus.frame_ready = 1'b1;
        for (int k = 0; k < 8; k++) push(k - 4, 3 - k);
        chk("t1_fill_full", bus.fill_level, 8);
        chk("t1_fv_not_yet", bus.frame_valid, 0);
        @(negedge clk);
        chk("t1_fv", bus.frame_valid, 1);
        chk("t1_xr0", xr_a[0], -4);
        chk("t1_xr7", xr_a[7], 3);
        chk("t1_xi0", xi_a[0], 3);
        chk("t1_xi7", xi_a[7], -4);
        chk("t1_cnt", bus.frame_cnt, 1);
        chk("t1_fill_empty", bus.fill_level, 0);
        chk("t1_ready_drops", ready_drops, 0);
        @(negedge clk);
        chk("t1_released", bus.frame_valid, 0);

        // 2: back-pressure with both buffers filled
        bus.frame_ready = 1'b0;
        ready_drops = 0;
        for (int k = 0; k < 8; k++) push(3 - k, k - 4);
        for (int k = 0; k < 8; k++) push(k - 4, (k % 2 == 1) ? 1 : -2);
        chk("t2_ready_drops", ready_drops, 0);
        chk("t2_in_ready", bus.in_ready, 0);
        chk("t2_fill", bus.fill_level, 8);
        chk("t2_fv", bus.frame_valid, 1);
        chk("t2_cnt", bus.frame_cnt, 2);
        chk("t2_hold_xr0", xr_a[0], 3);
        chk("t2_hold_xi7", xi_a[7], 3);
        @(negedge clk);
        chk("t2_stable_xr0", xr_a[0], 3);
        chk("t2_stable_fill", bus.fill_level, 8);
        bus.frame_ready = 1'b1;
        #1;
        chk("t2_comb_release", bus.in_ready, 1);
        @(negedge clk);
        bus.frame_ready = 1'b0;
        chk("t2_new_xr0", xr_a[0], -4);
        chk("t2_new_xr7", xr_a[7], 3);
        chk("t2_new_xi0", xi_a[0], -2);
        chk("t2_new_xi7", xi_a[7], 1);
        chk("t2_new_fv", bus.frame_valid, 1);
        chk("t2_new_cnt", bus.frame_cnt, 3);
        chk("t2_new_ready", bus.in_ready, 1);
        chk("t2_new_fill", bus.fill_level, 0);
        bus.frame_ready = 1'b1;
        @(negedge clk);
        chk("t2_released", bus.frame_valid, 0);

        // 3: abort over a concurrent 6th sample
        for (int k = 0; k < 5; k++) push(1, 1);
        chk("t3_fill5", bus.fill_level, 5);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_re    = 3'b111;
        bus.in_im    = 3'b111;
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("t3_fill_abort", bus.fill_level, 0);
        chk("t3_cnt_abort", bus.frame_cnt, 3);
        for (int k = 0; k < 8; k++) push(3 - k, k - 4);
        @(negedge clk);
        chk("t3_fv", bus.frame_valid, 1);
        chk("t3_cnt", bus.frame_cnt, 4);
        chk("t3_xr0", xr_a[0], 3);
        chk("t3_xr5", xr_a[5], -2);
        chk("t3_xi0", xi_a[0], -4);
        chk("t3_xi7", xi_a[7], 3);

        // 4: four frames streamed without gaps
        ready_drops = 0;
        for (int j = 0; j < 32; j++) push((j % 8) - 4, 3 - (j % 8));
        chk("t4_cnt_before_last", bus.frame_cnt, 7);
        @(negedge clk);
        chk("t4_cnt", bus.frame_cnt, 8);
        chk("t4_xr7", xr_a[7], 3);
        chk("t4_xi0", xi_a[0], 3);
        chk("t4_ready_drops", ready_drops, 0);

        // 5: asynchronous reset mid-frame with a held frame
        bus.frame_ready = 1'b0;
        for (int k = 0; k < 6; k++) push(2, -3);
        chk("t5_fill6", bus.fill_level, 6);
        chk("t5_fv_held", bus.frame_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_ready", bus.in_ready, 0);
        chk("t5_rst_fv", bus.frame_valid, 0);
        chk("t5_rst_fill", bus.fill_level, 0);
        chk("t5_rst_cnt", bus.frame_cnt, 0);
        chk("t5_rst_xr0", xr_a[0], 0);
        chk("t5_rst_xi7", xi_a[7], 0);
        @(negedge clk);
        rst = 1'b1;
        bus.frame_ready = 1'b1;
        for (int k = 0; k < 8; k++) push(k - 4, 3 - k);
        @(negedge clk);
        chk("t5_fv", bus.frame_valid, 1);
        chk("t5_xr3", xr_a[3], -1);
        chk("t5_xi3", xi_a[3], 0);
        chk("t5_xr6", xr_a[6], 2);
        chk("t5_cnt", bus.frame_cnt, 1);

        // 6: extreme component values
        for (int k = 0; k < 8; k++) push(-4, 3);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_xr%0d", i), xr_a[i], -4);
            chk($sformatf("t6_xi%0d", i), xi_a[i], 3);
        end
        chk("t6_cnt", bus.frame_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dit_frame_loader.md
Name: dit_frame_loader

Overview:
- Upstream stage of the 8-point radix-2 DIT FFT core.
- Accepts complex samples one per transfer on a valid/ready stream and assembles them into 8-sample frames in natural order.
- Presents each complete frame in parallel on xr0..xr7 / xi0..xi7, with a frame-level valid/ready handshake to the FFT-side consumer.
- Double-buffered (load buffer plus hold buffer), so the next frame can stream in while the current one is held.

Parameters:
- DW, 3, sample component width (signed two's complement); matches the FFT input width.
- CW, 8, width of the frame counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  loader can accept a sample.
- in_re  in  DW  sample real part, signed.
- in_im  in  DW  sample imaginary part, signed.
- abort  in  1  synchronous discard of the partially or fully loaded, not-yet-transferred frame.
- frame_valid  out  1  hold buffer contains a complete frame.
- frame_ready  in  1  consumer takes the held frame this cycle.
- xr0..xr7  out  DW each  held frame, real parts; sample k appears on xr k.
- xi0..xi7  out  DW each  held frame, imaginary parts; sample k appears on xi k.
- frame_cnt  out  CW  number of frames transferred to the hold buffer, modulo 2^CW.
- fill_level  out  4  samples currently in the load buffer (0..8).

Behaviour:
- Reset (rst low, asynchronous):
  - Clears wr_cnt (3 bits), load_full, frame_valid, frame_cnt, and all load and hold registers (xr*/xi* = 0).
  - in_ready is forced 0 while rst is low.
  - After release, in_ready = 1 and fill_level = 0.
- Accept:
  - A sample is accepted when in_valid && in_ready at the rising edge.
  - It is written to load slot wr_cnt, and wr_cnt increments.
  - The 8th accept (wr_cnt == 7) sets load_full and wraps wr_cnt to 0.
- Transfer condition: xfer = load_full && (!frame_valid || frame_ready).
- On xfer:
  - hold <= load (all 16 components), frame_valid <= 1, frame_cnt increments (wraps).
  - load_full <= 0, unless a new 8th sample is accepted in the same cycle; that cannot happen, because wr_cnt is 0 at that point.
- in_ready = !load_full || xfer, which gives combinational back-pressure release.
  - A sample accepted in an xfer cycle lands in slot 0.
  - The hold copy uses pre-edge load contents.
  - Sustained throughput is 8 samples per 8 cycles when frame_ready is held high.
- Latency: 8th sample accepted at edge N -> frame_valid = 1 and xr*/xi* valid after edge N+1, provided the hold is free.
- Release: frame_valid && frame_ready && !xfer clears frame_valid. When xfer coincides with release, frame_valid stays 1 and the new frame replaces the old one.
- Hold stability: xr*/xi* change only on xfer; they are stable for as long as frame_valid is high without frame_ready.
- fill_level = load_full ? 8 : wr_cnt.
- Back-pressure when both buffers are full: load_full = 1, frame_valid = 1, frame_ready = 0 -> in_ready = 0 and no state changes.
- abort:
  - Clears wr_cnt and load_full; load data is not cleared.
  - Takes priority over an accept and over xfer in the same cycle: no transfer occurs and the sample is dropped.
  - Hold buffer, frame_valid and frame_cnt are unaffected.
- Reset mid-frame discards both buffers immediately. No partial frame is ever presented.
- Arithmetic: none. Data passes through bit-exact with sign preserved.

Test Plan:
1. Reset then 8 samples back-to-back (re = k-4, im = 3-k for k = 0..7), frame_ready = 1 -> frame_valid rises 1 cycle after the 8th accept; xr0 = -4, xr7 = 3, xi0 = 3, xi7 = -4; frame_cnt = 1; in_ready never drops.
2. frame_ready = 0, stream 16 samples -> first frame held unchanged; after the 16th accept in_ready = 0 and fill_level = 8. Pulse frame_ready for 1 cycle -> second frame appears on the next edge, in_ready = 1, frame_cnt = 2.
3. 5 samples, then abort asserted concurrent with a valid 6th sample -> fill_level = 0 and the sample is dropped. Next 8 samples form the frame; frame_cnt increments only once.
4. Continuous stream of 4 frames with frame_ready = 1 -> one frame every 8 cycles, frame_cnt = 4, zero idle cycles on in_ready.
5. Assert rst low asynchronously (between edges) while fill_level = 6 and frame_valid = 1 -> all outputs 0 immediately and in_ready = 0. After release, a fresh 8-sample frame loads correctly.
6. Extremes: all samples re = -4, im = 3 -> outputs exactly -4 and 3, with no sign or width corruption.
